// File: rtl/menu_selector_if.sv
// Signal bundle between the menu selector and the game side: sample strobe,
// raw buttons and game_done in, registered mode/select status out.
interface menu_selector_if #(
    parameter int MODE_W = 2
);
    logic              tick_i;
    logic              btn_up_i;
    logic              btn_down_i;
    logic              btn_sel_i;
    logic              btn_back_i;
    logic              game_done_i;
    logic [MODE_W-1:0] mode_o;
    logic              selected_o;
    logic              mode_changed_o;
    logic              sel_pulse_o;

    modport master (
        output tick_i, btn_up_i, btn_down_i, btn_sel_i, btn_back_i, game_done_i,
        input  mode_o, selected_o, mode_changed_o, sel_pulse_o
    );

    modport slave (
        input  tick_i, btn_up_i, btn_down_i, btn_sel_i, btn_back_i, game_done_i,
        output mode_o, selected_o, mode_changed_o, sel_pulse_o
    );
endinterface

// File: rtl/menu_selector.sv
// N-way mode menu for the reaction game: synchronised, tick-debounced buttons
// with hold-to-repeat on up/down, and a BROWSE/LOCKED selection FSM.
module menu_selector #(
    parameter int NUM_MODES      = 3,
    parameter int MODE_W         = 2,
    parameter int DEFAULT_MODE   = 1,
    parameter int WRAP           = 0,
    parameter int DEBOUNCE_TICKS = 2,
    parameter int REPEAT_TICKS   = 5
) (
    input logic         clk,
    input logic         rst,
    menu_selector_if.slave bus
);
    localparam int B_UP   = 0;
    localparam int B_DOWN = 1;
    localparam int B_SEL  = 2;
    localparam int B_BACK = 3;
    localparam int DB_W   = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int RP_W   = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [MODE_W-1:0] TOP_MODE = MODE_W'(NUM_MODES - 1);

    typedef enum logic {BROWSE, LOCKED} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              raw;
    logic [3:0]              meta_q, sync_q;
    logic [1:0]              rdy_q;
    logic [3:0]              arm_q;
    logic [3:0]              deb_q, deb_d;
    logic [3:0][DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic [3:0]              press_q, press_d;
    logic [1:0]              rep_q, rep_d;
    logic [1:0][RP_W-1:0]    rep_cnt_q, rep_cnt_d;
    logic [MODE_W-1:0]       mode_q, mode_d;
    logic                    mode_changed_q, mode_changed_d;
    logic                    sel_pulse_q, sel_pulse_d;
    logic                    up_ev, dn_ev, sel_ev, back_ev;

    assign raw = {bus.btn_back_i, bus.btn_sel_i, bus.btn_down_i, bus.btn_up_i};

    // A button only arms once it is seen released after reset, so a press held
    // through reset never produces an event.
    // NOTE: non-blocking assignments make every flop sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q    <= '0;
            sync_q    <= '0;
            rdy_q     <= '0;
            arm_q     <= '0;
            deb_q     <= '0;
            db_cnt_q  <= '0;
            press_q   <= '0;
            rep_q     <= '0;
            rep_cnt_q <= '0;
        end else begin
            meta_q    <= raw;
            sync_q    <= meta_q;
            rdy_q     <= {rdy_q[0], 1'b1};
            arm_q     <= arm_q | ({4{rdy_q[1]}} & ~sync_q);
            deb_q     <= deb_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            rep_q     <= rep_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    // NOTE: defaults first so every path assigns and no latch is inferred.
    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = db_cnt_q;
        press_d  = '0;
        for (int b = 0; b < 4; b++) begin
            if (bus.tick_i) begin
                if (sync_q[b] != deb_q[b]) begin
                    if (db_cnt_q[b] == DB_W'(DEBOUNCE_TICKS - 1)) begin
                        deb_d[b]    = sync_q[b];
                        db_cnt_d[b] = '0;
                        press_d[b]  = sync_q[b] & arm_q[b];
                    end else begin
                        db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                    end
                end else begin
                    db_cnt_d[b] = '0;
                end
            end
        end
    end

    // Repeat timer runs only while a held up/down stays debounced high in BROWSE.
    always_comb begin
        rep_d     = '0;
        rep_cnt_d = '0;
        for (int r = 0; r < 2; r++) begin
            if (REPEAT_TICKS > 0 && state_q == BROWSE && arm_q[r] && deb_q[r] && deb_d[r]) begin
                rep_cnt_d[r] = rep_cnt_q[r];
                if (bus.tick_i) begin
                    if (rep_cnt_q[r] == RP_W'(REPEAT_TICKS - 1)) begin
                        rep_d[r]     = 1'b1;
                        rep_cnt_d[r] = '0;
                    end else begin
                        rep_cnt_d[r] = rep_cnt_q[r] + 1'b1;
                    end
                end
            end
        end
    end

    assign up_ev   = press_q[B_UP] | rep_q[B_UP];
    assign dn_ev   = press_q[B_DOWN] | rep_q[B_DOWN];
    assign sel_ev  = press_q[B_SEL];
    assign back_ev = press_q[B_BACK];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= BROWSE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BROWSE:  if (sel_ev) state_d = LOCKED;
            LOCKED:  if (back_ev || bus.game_done_i) state_d = BROWSE;
            default: state_d = BROWSE;
        endcase
    end

    // Select beats any step in the same cycle; opposing steps cancel.
    always_comb begin
        mode_d      = mode_q;
        sel_pulse_d = 1'b0;
        if (state_q == BROWSE) begin
            if (sel_ev) begin
                sel_pulse_d = 1'b1;
            end else if (up_ev && !dn_ev) begin
                if (mode_q == TOP_MODE) mode_d = (WRAP != 0) ? '0 : mode_q;
                else                    mode_d = mode_q + 1'b1;
            end else if (dn_ev && !up_ev) begin
                if (mode_q == '0) mode_d = (WRAP != 0) ? TOP_MODE : mode_q;
                else              mode_d = mode_q - 1'b1;
            end
        end
        mode_changed_d = (mode_d != mode_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q         <= MODE_W'(DEFAULT_MODE);
            mode_changed_q <= 1'b0;
            sel_pulse_q    <= 1'b0;
        end else begin
            mode_q         <= mode_d;
            mode_changed_q <= mode_changed_d;
            sel_pulse_q    <= sel_pulse_d;
        end
    end

    assign bus.mode_o         = mode_q;
    assign bus.selected_o     = (state_q == LOCKED);
    assign bus.mode_changed_o = mode_changed_q;
    assign bus.sel_pulse_o    = sel_pulse_q;
endmodule
